// File: rtl/arb_pkg.sv
// Shared types for the CPU/DMA memory-port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} arb_owner_t;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, contention goes to the
// requester that did not own the port last.
module rr_pick2
  import arb_pkg::*;
(
  input  logic       cpu_req_i,
  input  logic       dma_req_i,
  input  arb_owner_t last_owner_i,
  output logic       grant_vld_o,
  output arb_owner_t grant_o
);

  always_comb begin
    grant_vld_o = cpu_req_i | dma_req_i;
    grant_o     = OWN_CPU;
    if (cpu_req_i && dma_req_i) begin
      grant_o = (last_owner_i == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (dma_req_i) begin
      grant_o = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter in front of the single memory port (IDLE->ISSUE->WAIT->RESP).
// Define ARB_TIMEOUT_EN to add a WAIT watchdog that completes with err=1.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [2:0]  dma_funct3,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        mem_ce,
  output logic        mem_memwrite,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  input  logic [31:0] mem_dataout,
  input  logic        mem_busy,
  input  logic        mem_valid,
  output logic        owner_dma
);

  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, owner_d;
  arb_owner_t  last_owner_q, last_owner_d;
  logic        cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
  logic        cpu_err_q, cpu_err_d, dma_err_q, dma_err_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic        grant_vld;
  arb_owner_t  grant;
  logic        timeout;

  rr_pick2 u_pick (
    .cpu_req_i    (cpu_req),
    .dma_req_i    (dma_req),
    .last_owner_i (last_owner_q),
    .grant_vld_o  (grant_vld),
    .grant_o      (grant)
  );

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == ARB_ISSUE) begin
      to_cnt_d = '0;
    end else if (state_q == ARB_WAIT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  assign timeout = (state_q == ARB_WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  // Sizing parameters only matter with the watchdog built in.
  logic unused_cfg;
  assign unused_cfg = ^TO_W'(TIMEOUT_CYCLES);
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    cpu_err_d    = 1'b0;
    dma_err_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_vld && !mem_busy) begin
          owner_d = grant;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        // A real completion beats a watchdog expiry in the same cycle.
        if (mem_valid || timeout) begin
          state_d      = ARB_RESP;
          last_owner_d = owner_q;
          if (owner_q == OWN_DMA) begin
            dma_ack_d   = 1'b1;
            dma_err_d   = !mem_valid;
            dma_rdata_d = mem_valid ? mem_dataout : ARB_ERR_DATA;
          end else begin
            cpu_ack_d   = 1'b1;
            cpu_err_d   = !mem_valid;
            cpu_rdata_d = mem_valid ? mem_dataout : ARB_ERR_DATA;
          end
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DMA;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      dma_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      cpu_err_q    <= cpu_err_d;
      dma_err_q    <= dma_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Memory-side fields are forced to zero outside ISSUE/WAIT so no stray write can leak.
  always_comb begin
    mem_memwrite = 1'b0;
    mem_funct3   = '0;
    mem_addr     = '0;
    mem_datain   = '0;
    if (state_q == ARB_ISSUE || state_q == ARB_WAIT) begin
      if (owner_q == OWN_DMA) begin
        mem_memwrite = dma_we;
        mem_funct3   = dma_funct3;
        mem_addr     = dma_addr;
        mem_datain   = dma_wdata;
      end else begin
        mem_memwrite = cpu_we;
        mem_funct3   = cpu_funct3;
        mem_addr     = cpu_addr;
        mem_datain   = cpu_wdata;
      end
    end
  end

  assign mem_ce    = (state_q == ARB_ISSUE);
  assign owner_dma = (state_q != ARB_IDLE) && (owner_q == OWN_DMA);
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_err   = cpu_err_q;
  assign dma_err   = dma_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the watchdog scenario is built only with ARB_TIMEOUT_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_funct3 = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [2:0]  dma_funct3 = '0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_ack, dma_err;
  logic [31:0] dma_rdata;
  logic        mem_ce, mem_memwrite;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_datain;
  logic [31:0] mem_dataout = '0;
  logic        mem_busy = 1'b0, mem_valid = 1'b0;
  logic        owner_dma;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_total = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_funct3(dma_funct3), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_ce(mem_ce), .mem_memwrite(mem_memwrite), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_dataout(mem_dataout),
    .mem_busy(mem_busy), .mem_valid(mem_valid), .owner_dma(owner_dma)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_ce === 1'b1) ce_total++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ce(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (mem_ce === 1'b1) seen = 1'b1;
    end
    check_eq({tag, "_ce_seen"}, 32'(seen), 32'd1);
  endtask

  // Called in the ISSUE cycle: completes after lat cycles of WAIT, leaves the bench in RESP.
  task automatic respond(input int lat, input logic [31:0] data);
    for (int i = 0; i < lat; i++) tick();
    mem_valid   = 1'b1;
    mem_dataout = data;
    tick();
    mem_valid   = 1'b0;
    mem_dataout = '0;
  endtask

  initial begin
    int ce0;
    bit exp_dma;
    // Reset with both requesters already asking.
    cpu_req = 1'b1; cpu_addr = 32'h10; cpu_funct3 = 3'b010;
    dma_req = 1'b1; dma_addr = 32'h20; dma_funct3 = 3'b010;
    repeat (3) tick();
    check_eq("rst_cpu_ack",   32'(cpu_ack), 32'd0);
    check_eq("rst_dma_ack",   32'(dma_ack), 32'd0);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    check_eq("rst_dma_rdata", dma_rdata, 32'd0);
    check_eq("rst_mem_ce",    32'(mem_ce), 32'd0);
    check_eq("rst_owner_dma", 32'(owner_dma), 32'd0);
    check_eq("rst_memwrite",  32'(mem_memwrite), 32'd0);
    check_eq("rst_mem_addr",  mem_addr, 32'd0);
    check_eq("rst_cpu_err",   32'(cpu_err), 32'd0);

    // Contention: strict alternation starting with the CPU.
    ce0 = ce_total;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_dma = (i % 2) == 1;
      wait_ce("rr");
      check_eq("rr_owner_dma", 32'(owner_dma), 32'(exp_dma));
      check_eq("rr_mem_addr", mem_addr, exp_dma ? 32'h20 : 32'h10);
      respond(2, 32'hC0DE_0000 + 32'(i));
      check_eq("rr_cpu_ack", 32'(cpu_ack), 32'(!exp_dma));
      check_eq("rr_dma_ack", 32'(dma_ack), 32'(exp_dma));
      check_eq("rr_resp_owner", 32'(owner_dma), 32'(exp_dma));
      check_eq("rr_rdata", exp_dma ? dma_rdata : cpu_rdata, 32'hC0DE_0000 + 32'(i));
      if (i == 3) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
    end
    repeat (3) tick();
    check_eq("rr_ce_count", 32'(ce_total - ce0), 32'd4);
    check_eq("rr_cpu_hold", cpu_rdata, 32'hC0DE_0002);
    check_eq("rr_dma_hold", dma_rdata, 32'hC0DE_0003);

    // CPU-only read, memory answers 5 cycles after mem_ce.
    ce0 = ce_total;
    cpu_addr = 32'h100; cpu_funct3 = 3'b100; cpu_we = 1'b0; cpu_req = 1'b1;
    wait_ce("rd");
    check_eq("rd_mem_addr", mem_addr, 32'h100);
    check_eq("rd_memwrite", 32'(mem_memwrite), 32'd0);
    check_eq("rd_funct3", 32'(mem_funct3), 32'd4);
    check_eq("rd_owner_dma", 32'(owner_dma), 32'd0);
    tick();
    check_eq("rd_wait_ack", 32'(cpu_ack), 32'd0);
    check_eq("rd_wait_addr", mem_addr, 32'h100);
    respond(4, 32'h1234_5678);
    check_eq("rd_cpu_ack", 32'(cpu_ack), 32'd1);
    check_eq("rd_cpu_rdata", cpu_rdata, 32'h1234_5678);
    check_eq("rd_cpu_err", 32'(cpu_err), 32'd0);
    check_eq("rd_dma_ack", 32'(dma_ack), 32'd0);
    check_eq("rd_resp_addr", mem_addr, 32'd0);
    cpu_req = 1'b0;
    tick();
    check_eq("rd_ack_pulse", 32'(cpu_ack), 32'd0);
    check_eq("rd_rdata_hold", cpu_rdata, 32'h1234_5678);
    check_eq("rd_ce_count", 32'(ce_total - ce0), 32'd1);

    // DMA word write.
    dma_we = 1'b1; dma_funct3 = 3'b010; dma_addr = 32'h2000; dma_wdata = 32'hA5A5_0001;
    dma_req = 1'b1;
    check_eq("wr_idle_memwrite", 32'(mem_memwrite), 32'd0);
    wait_ce("wr");
    check_eq("wr_memwrite", 32'(mem_memwrite), 32'd1);
    check_eq("wr_datain", mem_datain, 32'hA5A5_0001);
    check_eq("wr_addr", mem_addr, 32'h2000);
    check_eq("wr_funct3", 32'(mem_funct3), 32'd2);
    check_eq("wr_owner_dma", 32'(owner_dma), 32'd1);
    tick();
    check_eq("wr_wait_memwrite", 32'(mem_memwrite), 32'd1);
    check_eq("wr_wait_datain", mem_datain, 32'hA5A5_0001);
    respond(1, 32'd0);
    check_eq("wr_dma_ack", 32'(dma_ack), 32'd1);
    check_eq("wr_cpu_ack", 32'(cpu_ack), 32'd0);
    check_eq("wr_resp_memwrite", 32'(mem_memwrite), 32'd0);
    check_eq("wr_resp_datain", mem_datain, 32'd0);
    dma_req = 1'b0; dma_we = 1'b0;
    tick();
    check_eq("wr_ack_pulse", 32'(dma_ack), 32'd0);

    // Memory busy stalls arbitration.
    ce0 = ce_total;
    mem_busy = 1'b1;
    cpu_addr = 32'h300; cpu_req = 1'b1;
    repeat (10) tick();
    check_eq("busy_no_ce", 32'(ce_total - ce0), 32'd0);
    check_eq("busy_ce_now", 32'(mem_ce), 32'd0);
    mem_busy = 1'b0;
    tick();
    check_eq("busy_ce_after", 32'(mem_ce), 32'd1);
    check_eq("busy_addr", mem_addr, 32'h300);
    respond(1, 32'h55AA_55AA);
    check_eq("busy_cpu_ack", 32'(cpu_ack), 32'd1);
    check_eq("busy_cpu_rdata", cpu_rdata, 32'h55AA_55AA);
    cpu_req = 1'b0;
    tick();

    // Reset while waiting on memory, then a late mem_valid.
    cpu_addr = 32'h400; cpu_req = 1'b1;
    wait_ce("rstw");
    tick();
    reset = 1'b0; cpu_req = 1'b0;
    tick();
    check_eq("rstw_mem_ce", 32'(mem_ce), 32'd0);
    check_eq("rstw_cpu_ack", 32'(cpu_ack), 32'd0);
    check_eq("rstw_owner_dma", 32'(owner_dma), 32'd0);
    check_eq("rstw_mem_addr", mem_addr, 32'd0);
    check_eq("rstw_rdata_clr", cpu_rdata, 32'd0);
    reset = 1'b1;
    mem_valid = 1'b1; mem_dataout = 32'hFFFF_0000;
    tick();
    mem_valid = 1'b0; mem_dataout = '0;
    check_eq("late_valid_ack", 32'(cpu_ack), 32'd0);
    tick();
    check_eq("late_valid_ack2", 32'(cpu_ack), 32'd0);
    check_eq("late_valid_rdata", cpu_rdata, 32'd0);
    check_eq("late_valid_ce", 32'(mem_ce), 32'd0);

`ifdef ARB_TIMEOUT_EN
    begin
      int n;
      bit got;
      logic        err_s;
      logic [31:0] rd_s;
      cpu_addr = 32'h500; cpu_req = 1'b1;
      wait_ce("to");
      n = 0; got = 1'b0; err_s = 1'b0; rd_s = '0;
      for (int k = 0; k < 30 && !got; k++) begin
        tick();
        n++;
        if (cpu_ack === 1'b1) begin
          got = 1'b1; err_s = cpu_err; rd_s = cpu_rdata;
        end
      end
      check_eq("to_ack_seen", 32'(got), 32'd1);
      check_eq("to_latency_17_18", 32'(n >= 17 && n <= 18), 32'd1);
      check_eq("to_err", 32'(err_s), 32'd1);
      check_eq("to_rdata", rd_s, 32'hDEAD_BEEF);
      cpu_req = 1'b0;
      dma_addr = 32'h600; dma_req = 1'b1;
      wait_ce("to_next");
      check_eq("to_next_owner_dma", 32'(owner_dma), 32'd1);
      respond(1, 32'h77);
      check_eq("to_next_dma_ack", 32'(dma_ack), 32'd1);
      check_eq("to_next_dma_err", 32'(dma_err), 32'd0);
      dma_req = 1'b0;
      tick();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the single `memory` port, shared between the CPU (fetch/load/store) and a DMA requester (radio sample capture/playback).
- Serialises transactions with round-robin fairness.
- Drives the memory ce/busy/valid handshake and returns read data and completion to the owning requester.
- Sits between `cpu` and `memory`.

Parameters:
- TIMEOUT_CYCLES, 4096, max cycles in WAIT before forced error completion (used only with ARB_TIMEOUT_EN).
- TO_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- cpu_req  in  1  CPU request; held high with stable fields until cpu_ack
- cpu_we  in  1  1 = store
- cpu_funct3  in  3  access size/sign (RV funct3 encoding)
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  32  load data, valid while cpu_ack=1
- cpu_err  out  1  timeout error, qualified by cpu_ack
- dma_req, dma_we, dma_funct3, dma_addr, dma_wdata, dma_ack, dma_rdata, dma_err: same widths and semantics for DMA
- mem_ce  out  1  one-cycle transaction start pulse
- mem_memwrite  out  1  to memory.memwrite
- mem_funct3  out  3  to memory.funct3
- mem_addr  out  32  to memory.addr
- mem_datain  out  32  to memory.datain
- mem_dataout  in  32  from memory
- mem_busy  in  1  memory busy
- mem_valid  in  1  memory completion pulse (reads and writes)
- owner_dma  out  1  1 while the DMA owns the port (debug/status)

Behaviour:
- Reset (reset=0, synchronous):
  - state=IDLE, last_owner=DMA (so the CPU wins the first tie).
  - All ack/err=0, rdata=0, mem_ce=0, owner_dma=0.
- States:
  - IDLE: if any req and !mem_busy, pick a winner, latch owner, go to ISSUE. Otherwise stay.
  - ISSUE: mem_ce=1 for exactly this cycle; go to WAIT.
  - WAIT: on mem_valid, capture mem_dataout into owner's rdata register, set last_owner=owner, go to RESP.
  - RESP: owner's ack=1 (registered pulse, one cycle), other ack=0; go to IDLE.
- Pick rule:
  - Only one requesting: it wins.
  - Both requesting: the requester != last_owner wins (strict alternation under contention).
- mem_addr/mem_funct3/mem_datain/mem_memwrite are muxed combinationally from the latched owner's inputs during ISSUE and WAIT.
  - In IDLE and RESP they are 0 and mem_memwrite=0, so a stray write is impossible.
- Latency: request seen in IDLE at cycle N → mem_ce at N+1 → ack one cycle after mem_valid.
  - Minimum request-to-ack is 3 cycles plus memory latency.
  - New arbitration in the IDLE following RESP: 1 dead cycle between transactions.
- rdata registers hold their value after ack until the next completion for that requester.
- mem_valid outside WAIT is ignored.
- Requester dropping req before ack is illegal; the in-flight transaction still completes and acks.
- Same requester re-asserting req right after ack: it competes normally and alternation still applies.
- owner_dma=1 in ISSUE/WAIT/RESP when the owner is DMA, else 0.
- Reset mid-transaction: returns to IDLE immediately with no ack. `memory` shares this reset.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Counter cleared on ISSUE, increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without mem_valid: go to RESP with owner's err=1 and rdata=32'hDEAD_BEEF.
  - last_owner is updated as normal.
- Undefined: no counter; WAIT lasts until mem_valid; err outputs tied to 0.

Decomposition:
- Package arb_pkg:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t
  - typedef enum logic {OWN_CPU, OWN_DMA} arb_owner_t
  - constant ARB_ERR_DATA = 32'hDEAD_BEEF
- One natural sub-module: rr_pick2 (combinational pick from two reqs and last_owner). Everything else stays in mem_arbiter.

Test Plan:
- CPU-only read, addr 0x100, memory returns 0x1234_5678 after 5 cycles → mem_ce one pulse with mem_addr=0x100, mem_memwrite=0; cpu_ack one cycle after mem_valid with cpu_rdata=0x1234_5678; dma_ack stays 0.
- Both req asserted from reset, held for 4 transactions → grant order CPU, DMA, CPU, DMA; owner_dma toggles accordingly; exactly 4 mem_ce pulses.
- DMA write, addr 0x2000, wdata 0xA5A5_0001, funct3=010 → mem_memwrite=1, mem_datain=0xA5A5_0001 during ISSUE/WAIT only; dma_ack after mem_valid; mem_memwrite=0 in IDLE.
- mem_busy=1 held for 10 cycles with cpu_req=1 → no mem_ce until mem_busy falls; mem_ce the cycle after the IDLE sample with mem_busy=0.
- reset=0 asserted during WAIT → next cycle state IDLE, mem_ce=0, no ack; a late mem_valid is ignored.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_valid never asserted → cpu_ack=1, cpu_err=1, cpu_rdata=32'hDEAD_BEEF 17–18 cycles after ISSUE; the next DMA request is then granted.
